// File: rtl/softmax_sched.sv
// Softmax scheduler: round-robin arbitration of NREQ requesters onto one softmax
// engine; streams the owner's frame in, then returns the result stream tagged with its id.
module softmax_sched #(
    parameter  int IBIT = 20,
    parameter  int OBIT = 11,
    parameter  int IDIM = 42,
    parameter  int NREQ = 4,
    parameter  int TMO  = 2048,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW   = $clog2(IDIM + 1),
    localparam int TW   = $clog2(TMO + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IBIT-1:0] req_data,
    output logic [NREQ-1:0]      grant,
    output logic                 rd_en,
    output logic                 sm_dv_in,
    output logic [IBIT-1:0]      sm_din,
    input  logic                 sm_dv_out,
    input  logic [OBIT-1:0]      sm_dout,
    output logic                 res_valid,
    output logic [OBIT-1:0]      res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 res_last,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_proto
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_LOAD, S_WAIT, S_DRAIN, S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            sm_dv_in_q, sm_dv_in_d;
    logic [IBIT-1:0] sm_din_q, sm_din_d;
    logic            res_valid_q, res_valid_d;
    logic [OBIT-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            res_last_q, res_last_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_proto_q, err_proto_d;

    logic [IBIT-1:0] slice [NREQ];
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    int              cand;

    always_comb begin
        for (int i = 0; i < NREQ; i++) slice[i] = req_data[i*IBIT +: IBIT];
    end

    // Walk downward so the final hit is the first set bit at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (req[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        sm_dv_in_d    = 1'b0;
        sm_din_d      = '0;
        res_valid_d   = 1'b0;
        res_data_d    = res_data_q;
        res_id_d      = res_id_q;
        res_last_d    = 1'b0;
        err_timeout_d = err_timeout_q;
        err_proto_d   = err_proto_q;
        rd_en         = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tmr_d = '0;
                if (win_found) begin
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    rr_ptr_d         = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d          = S_GRANT;
                end
            end
            S_GRANT: state_d = S_LOAD;
            S_LOAD: begin
                rd_en      = 1'b1;
                sm_dv_in_d = 1'b1;
                sm_din_d   = slice[owner_q];
                if (cnt_q == CW'(IDIM - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // WAIT and DRAIN share the capture path; cnt is 0 on entry to WAIT.
            S_WAIT, S_DRAIN: begin
                if (sm_dv_out) begin
                    res_valid_d = 1'b1;
                    res_data_d  = sm_dout;
                    res_id_d    = owner_q;
                    tmr_d       = '0;
                    if (cnt_q == CW'(IDIM - 1)) begin
                        res_last_d = 1'b1;
                        cnt_d      = '0;
                        grant_d    = '0;
                        state_d    = S_GAP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_DRAIN;
                    end
                end else if (state_q == S_WAIT) begin
                    if (tmr_q == TW'(TMO - 1)) begin
                        err_timeout_d = 1'b1;
                        tmr_d         = '0;
                        grant_d       = '0;
                        state_d       = S_GAP;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (sm_dv_out && (state_q inside {S_IDLE, S_GRANT, S_LOAD, S_GAP})) err_proto_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            sm_dv_in_q    <= 1'b0;
            sm_din_q      <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_id_q      <= '0;
            res_last_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_proto_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            sm_dv_in_q    <= sm_dv_in_d;
            sm_din_q      <= sm_din_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_id_q      <= res_id_d;
            res_last_q    <= res_last_d;
            err_timeout_q <= err_timeout_d;
            err_proto_q   <= err_proto_d;
        end
    end

    assign grant       = grant_q;
    assign sm_dv_in    = sm_dv_in_q;
    assign sm_din      = sm_din_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_id      = res_id_q;
    assign res_last    = res_last_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_timeout_q;
    assign err_proto   = err_proto_q;

endmodule
